// File: rtl/bpsk_frame_tx.sv
// Framed BPSK transmitter: 13-chip Barker preamble, PRBS7 payload, silent gap, optional looping.
// Define BPSK_DIFF_EN to differentially encode payload bits before modulation.
module bpsk_frame_tx #(
  parameter int unsigned CLK_PER_SYM = 10,
  parameter int unsigned PAYLOAD_LEN = 32,
  parameter int unsigned GAP_LEN     = 4
) (
  input  logic        clk_sig,
  input  logic        rst_n,
  input  logic        start,
  input  logic        loop_en,
  input  logic [15:0] carrier_sig,
  output logic [15:0] txd_sig,
  output logic        busy,
  output logic        sym_strobe,
  output logic        frame_done
);

  localparam int unsigned PreLen = 13;
  localparam int unsigned MaxSym = (PAYLOAD_LEN > PreLen) ?
      ((PAYLOAD_LEN > GAP_LEN) ? PAYLOAD_LEN : GAP_LEN) :
      ((GAP_LEN > PreLen) ? GAP_LEN : PreLen);
  localparam int unsigned CW = $clog2(CLK_PER_SYM);
  localparam int unsigned SW = $clog2(MaxSym);
  // First chip sits in the MSB so a left shift by the symbol index exposes it at bit 12.
  localparam logic [12:0] Barker = 13'b1111100110101;

  typedef enum logic [1:0] {StIdle, StPreamble, StPayload, StGap} state_e;

  state_e        state_q;
  logic [CW-1:0] cyc_q;
  logic [SW-1:0] sym_q;
  logic [6:0]    lfsr_q;
`ifdef BPSK_DIFF_EN
  logic          dprev_q;
`endif

  logic        cyc_last;
  logic        pre_last;
  logic        pay_last;
  logic        gap_last;
  logic        frame_end;
  logic [12:0] barker_sh;
  logic        pay_bit;
  logic        mod_bit;
  logic        mod_en;
  logic [15:0] carrier_neg;
  logic [15:0] tx_next;

  assign cyc_last = (cyc_q == CW'(CLK_PER_SYM - 1));
  assign pre_last = (sym_q == SW'(PreLen - 1));
  assign pay_last = (sym_q == SW'(PAYLOAD_LEN - 1));
  assign gap_last = (GAP_LEN != 0) && (sym_q == SW'(GAP_LEN - 1));

  assign frame_end = cyc_last &&
      (((state_q == StGap) && gap_last) ||
       ((state_q == StPayload) && pay_last && (GAP_LEN == 0)));

  assign barker_sh = Barker << sym_q;

`ifdef BPSK_DIFF_EN
  assign pay_bit = lfsr_q[6] ^ dprev_q;
`else
  assign pay_bit = lfsr_q[6];
`endif

  // Two's-complement negation overflows only for the most negative code; clamp it.
  assign carrier_neg = (carrier_sig == 16'h8000) ? 16'h7fff : (16'h0000 - carrier_sig);

  always_comb begin
    mod_en  = 1'b0;
    mod_bit = 1'b0;
    case (state_q)
      StPreamble: begin
        mod_en  = 1'b1;
        mod_bit = barker_sh[12];
      end
      StPayload: begin
        mod_en  = 1'b1;
        mod_bit = pay_bit;
      end
      default: ;
    endcase
    if (!mod_en) begin
      tx_next = '0;
    end else begin
      tx_next = mod_bit ? carrier_sig : carrier_neg;
    end
  end

  assign sym_strobe = ((state_q == StPreamble) || (state_q == StPayload)) && (cyc_q == '0);
  assign frame_done = frame_end;

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      sym_q   <= '0;
      lfsr_q  <= 7'h7f;
      txd_sig <= '0;
      busy    <= 1'b0;
`ifdef BPSK_DIFF_EN
      dprev_q <= 1'b1;
`endif
    end else begin
      txd_sig <= tx_next;
      if (state_q != StIdle) begin
        cyc_q <= cyc_last ? '0 : cyc_q + CW'(1);
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StPreamble;
            busy    <= 1'b1;
            cyc_q   <= '0;
            sym_q   <= '0;
`ifdef BPSK_DIFF_EN
            dprev_q <= 1'b1;
`endif
          end
        end
        StPreamble: begin
          if (cyc_last) begin
            if (pre_last) begin
              sym_q   <= '0;
              state_q <= StPayload;
            end else begin
              sym_q <= sym_q + SW'(1);
            end
          end
        end
        StPayload: begin
          if (cyc_last) begin
            lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
`ifdef BPSK_DIFF_EN
            dprev_q <= pay_bit;
`endif
            if (pay_last) begin
              sym_q <= '0;
              if (GAP_LEN == 0) begin
                if (loop_en) begin
                  state_q <= StPreamble;
`ifdef BPSK_DIFF_EN
                  dprev_q <= 1'b1;
`endif
                end else begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
                end
              end else begin
                state_q <= StGap;
              end
            end else begin
              sym_q <= sym_q + SW'(1);
            end
          end
        end
        StGap: begin
          if (cyc_last) begin
            if (gap_last) begin
              sym_q <= '0;
              if (loop_en) begin
                state_q <= StPreamble;
`ifdef BPSK_DIFF_EN
                dprev_q <= 1'b1;
`endif
              end else begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end
            end else begin
              sym_q <= sym_q + SW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_frame_tx.sv
// Bench for bpsk_frame_tx: two instances (default and gapless/looping) against a frame-timeline model.
module tb_bpsk_frame_tx;

  logic        clk_sig = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start      [2];
  logic        loop_en    [2];
  logic [15:0] carrier    [2];
  logic [15:0] txd        [2];
  logic        busy       [2];
  logic        sym_strobe [2];
  logic        frame_done [2];

  always #5 clk_sig = ~clk_sig;

  bpsk_frame_tx dut0 (
    .clk_sig     (clk_sig),
    .rst_n       (rst_n),
    .start       (start[0]),
    .loop_en     (loop_en[0]),
    .carrier_sig (carrier[0]),
    .txd_sig     (txd[0]),
    .busy        (busy[0]),
    .sym_strobe  (sym_strobe[0]),
    .frame_done  (frame_done[0])
  );

  bpsk_frame_tx #(
    .CLK_PER_SYM (3),
    .PAYLOAD_LEN (8),
    .GAP_LEN     (0)
  ) dut1 (
    .clk_sig     (clk_sig),
    .rst_n       (rst_n),
    .start       (start[1]),
    .loop_en     (loop_en[1]),
    .carrier_sig (carrier[1]),
    .txd_sig     (txd[1]),
    .busy        (busy[1]),
    .sym_strobe  (sym_strobe[1]),
    .frame_done  (frame_done[1])
  );

  int vectors     = 0;
  int miscompares = 0;

  bit          rnd_carrier [2];
  bit          seq [127];
  bit [12:0]   barker = 13'b1111100110101;

  // Reference model: position within the frame timeline plus payload symbol count since reset.
  bit          m_active [2];
  int          m_k      [2];
  int          m_pidx   [2];
  bit          m_dprev  [2];
  logic [15:0] m_txd    [2];
  int          m_frames [2];
  int          o_frames [2];

  function automatic int cps(int i);
    return (i == 0) ? 10 : 3;
  endfunction

  function automatic int pl(int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic int gl(int i);
    return (i == 0) ? 4 : 0;
  endfunction

  function automatic logic [15:0] neg16(logic [15:0] c);
    return (c == 16'h8000) ? 16'h7fff : (16'h0000 - c);
  endfunction

  task automatic check(string tag, int i, logic [15:0] obs, logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s[%0d] t=%0t observed=%h expected=%h", tag, i, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_k[i]      = 0;
      m_pidx[i]   = 0;
      m_dprev[i]  = 1'b1;
      m_txd[i]    = '0;
    end
  endtask

  task automatic model_edge(int i, bit st, bit lp, logic [15:0] c);
    int          sym;
    int          total;
    bit          d;
    logic [15:0] nxt;
    sym   = m_k[i] / cps(i);
    total = 13 + pl(i) + gl(i);
    nxt   = '0;
    if (m_active[i]) begin
      if (sym < 13) begin
        nxt = barker[12 - sym] ? c : neg16(c);
      end else if (sym < 13 + pl(i)) begin
        d = seq[m_pidx[i] % 127];
`ifdef BPSK_DIFF_EN
        d = d ^ m_dprev[i];
`endif
        nxt = d ? c : neg16(c);
        if (m_k[i] % cps(i) == cps(i) - 1) begin
          m_pidx[i]++;
          m_dprev[i] = d;
        end
      end
      m_k[i]++;
      if (m_k[i] == total * cps(i)) begin
        m_k[i]     = 0;
        m_dprev[i] = 1'b1;
        if (!lp) m_active[i] = 1'b0;
      end
    end else if (st) begin
      m_active[i] = 1'b1;
      m_k[i]      = 0;
      m_dprev[i]  = 1'b1;
    end
    m_txd[i] = nxt;
  endtask

  task automatic check_outputs();
    bit e_strobe;
    bit e_done;
    for (int i = 0; i < 2; i++) begin
      e_strobe = m_active[i] && (m_k[i] % cps(i) == 0) && (m_k[i] / cps(i) < 13 + pl(i));
      e_done   = m_active[i] && (m_k[i] == (13 + pl(i) + gl(i)) * cps(i) - 1);
      m_frames[i] += int'(e_done);
      o_frames[i] += int'(frame_done[i] === 1'b1);
      check("txd_sig", i, txd[i], m_txd[i]);
      check("busy", i, {15'd0, busy[i]}, {15'd0, m_active[i]});
      check("sym_strobe", i, {15'd0, sym_strobe[i]}, {15'd0, e_strobe});
      check("frame_done", i, {15'd0, frame_done[i]}, {15'd0, e_done});
    end
  endtask

  function automatic logic [15:0] rand_carrier();
    return ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
  endfunction

  task automatic step();
    bit          st [2];
    bit          lp [2];
    logic [15:0] c  [2];
    for (int i = 0; i < 2; i++) begin
      st[i] = start[i];
      lp[i] = loop_en[i];
      c[i]  = carrier[i];
    end
    @(posedge clk_sig);
    #1;
    for (int i = 0; i < 2; i++) model_edge(i, st[i], lp[i], c[i]);
    check_outputs();
    for (int i = 0; i < 2; i++) begin
      if (rnd_carrier[i]) carrier[i] = rand_carrier();
    end
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk_sig);
    rst_n = 1'b1;
  endtask

  initial begin
    bit [6:0] s;
    s = 7'h7f;
    for (int n = 0; n < 127; n++) begin
      seq[n] = s[6];
      s = {s[5:0], s[6] ^ s[5]};
    end
    for (int i = 0; i < 2; i++) begin
      start[i]       = 1'b0;
      loop_en[i]     = 1'b0;
      carrier[i]     = '0;
      rnd_carrier[i] = 1'b0;
      m_frames[i]    = 0;
      o_frames[i]    = 0;
    end
    model_reset();

    // Outputs under reset, then start on the very first edge after release.
    #12;
    check_outputs();
    @(negedge clk_sig);
    rst_n      = 1'b1;
    start[0]   = 1'b1;
    carrier[0] = 16'd1000;
    carrier[1] = 16'd1000;
    step();
    start[0] = 1'b0;
    repeat (499) step();
    check("frames_after_first", 0, 16'(o_frames[0]), 16'(m_frames[0]));

    // Random carrier (heavy on -32768), looping on both, random start pulses while busy.
    rnd_carrier[0] = 1'b1;
    rnd_carrier[1] = 1'b1;
    loop_en[0]     = 1'b1;
    loop_en[1]     = 1'b1;
    start[0]       = 1'b1;
    start[1]       = 1'b1;
    step();
    for (int n = 0; n < 1100; n++) begin
      start[0] = 1'($urandom_range(0, 1));
      start[1] = 1'($urandom_range(0, 1));
      step();
    end
    loop_en[0] = 1'b0;
    loop_en[1] = 1'b0;
    for (int n = 0; n < 300; n++) begin
      start[0] = 1'($urandom_range(0, 1));
      start[1] = 1'($urandom_range(0, 1));
      step();
    end
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (600) step();
    check("frames_loop0", 0, 16'(o_frames[0]), 16'(m_frames[0]));
    check("frames_loop1", 1, 16'(o_frames[1]), 16'(m_frames[1]));

    // Abort mid-payload, then a fresh frame must replay the payload from the reset seed.
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (13 * 10 + 55) step();
    pulse_reset();
    start[0] = 1'b1;
    start[1] = 1'b1;
    step();
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (500) step();
    check("frames_final0", 0, 16'(o_frames[0]), 16'(m_frames[0]));
    check("frames_final1", 1, 16'(o_frames[1]), 16'(m_frames[1]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
